// File: rtl/measure_seq_pkg.sv
// Shared constants and types for the measurement sequencer and the
// accumulate / divide / store datapath it drives.
//   - seq_state_t : sequencer state encoding
//   - FRAME_PAD, STORE_OFFSET : frame geometry relative to POINTS
//   - MEASURE_W, POINT_W, SAVE_W : counter widths shared with the datapath
package measure_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_RUN       = 2'd2
  } seq_state_t;

  localparam int FRAME_PAD      = 16;
  localparam int STORE_OFFSET   = 10;
  localparam int SAVE_DEPTH_DEF = 10;

  localparam int MEASURE_W = 17;
  localparam int POINT_W   = 11;
  localparam int SAVE_W    = 4;

  function automatic int frame_len(input int points);
    return 2 * points + FRAME_PAD;
  endfunction

  function automatic int store_at(input int points);
    return 2 * points + STORE_OFFSET;
  endfunction

endpackage

// File: rtl/measure_sequencer_counter.sv
// Modulo-MODULUS up-counter with synchronous clear, count enable and a
// combinational wrap pulse.
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance by one (wraps to 0 after MODULUS-1)
//   clr      : force count to 0 (priority over en)
//   count    : current value
//   wrap     : high when en is set and count is at MODULUS-1
module seq_wrap_counter #(
  parameter int WIDTH   = 8,
  parameter int MODULUS = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  output logic [WIDTH-1:0] count,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

  assign wrap = en && (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= wrap ? '0 : count + WIDTH'(1);
    end
  end

endmodule

// File: rtl/measure_sequencer.sv
// Frame/batch timing generator for the Raman acquisition chain.
// Each frame waits for its own trig, then sweeps cnt_measure over
// FRAME_LEN cycles; MEASURES frames form a batch. One store strobe per
// batch (frame 0, cycle STORE_AT) unless switch is set.
//   clk, rst      : clock, asynchronous active-high reset
//   start         : pulse, begins acquisition from IDLE
//   stop          : pulse, latched, honoured at the next batch end
//   switch_req    : requested mode, sampled on start and at batch ends
//   trig          : frame trigger, used only while waiting for a frame
//   cnt_measure   : cycle index within the frame
//   cnt_point     : frame index within the batch
//   cnt_save      : results stored, saturating at SAVE_DEPTH
//   switch        : active mode (1 suppresses storing)
//   store_strobe  : datapath capture pulse
//   frame_active  : in RUN
//   busy          : not IDLE
//   done          : pulse when cnt_save reaches SAVE_DEPTH
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | stopped, counters hold their last values
// WAIT_TRIG | armed, waiting for the next frame trigger
// RUN       | sweeping cnt_measure through one frame
module measure_sequencer
  import measure_seq_pkg::*;
#(
  parameter int POINTS     = 64,
  parameter int MEASURES   = 100,
  parameter int SAVE_DEPTH = SAVE_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 stop,
  input  logic                 switch_req,
  input  logic                 trig,
  output logic [MEASURE_W-1:0] cnt_measure,
  output logic [POINT_W-1:0]   cnt_point,
  output logic [SAVE_W-1:0]    cnt_save,
  output logic                 switch,
  output logic                 store_strobe,
  output logic                 frame_active,
  output logic                 busy,
  output logic                 done
);

  localparam int FRAME_LEN = frame_len(POINTS);
  localparam int STORE_AT  = store_at(POINTS);

  // The strobe is registered, so it is set one cycle ahead of STORE_AT.
  localparam logic [MEASURE_W-1:0] STORE_PRE = MEASURE_W'(STORE_AT - 1);
  localparam logic [SAVE_W-1:0]    SAVE_FULL = SAVE_W'(SAVE_DEPTH);
  localparam logic [SAVE_W-1:0]    SAVE_LAST = SAVE_W'(SAVE_DEPTH - 1);

  if (FRAME_LEN > 2 ** MEASURE_W) begin : g_chk_frame
    $error("measure_sequencer: FRAME_LEN exceeds cnt_measure range");
  end
  if (MEASURES < 1 || MEASURES > 2 ** POINT_W) begin : g_chk_measures
    $error("measure_sequencer: MEASURES must be 1..2048");
  end
  if (SAVE_DEPTH < 1 || SAVE_DEPTH >= 2 ** SAVE_W) begin : g_chk_save
    $error("measure_sequencer: SAVE_DEPTH does not fit cnt_save");
  end

  seq_state_t state, state_next;
  logic       stop_latch;
  logic       start_go;
  logic       run;
  logic       measure_wrap;
  logic       batch_end;
  logic       stop_now;

  assign start_go = (state == ST_IDLE) && start;
  assign run      = (state == ST_RUN);
  // A stop arriving on the batch-end cycle itself still counts.
  assign stop_now = stop_latch || stop;

  seq_wrap_counter #(
    .WIDTH  (MEASURE_W),
    .MODULUS(FRAME_LEN)
  ) u_measure (
    .clk  (clk),
    .rst  (rst),
    .en   (run),
    .clr  (start_go),
    .count(cnt_measure),
    .wrap (measure_wrap)
  );

  seq_wrap_counter #(
    .WIDTH  (POINT_W),
    .MODULUS(MEASURES)
  ) u_point (
    .clk  (clk),
    .rst  (rst),
    .en   (measure_wrap),
    .clr  (start_go),
    .count(cnt_point),
    .wrap (batch_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    unique case (state)
      ST_IDLE: begin
        if (start) state_next = ST_WAIT_TRIG;
      end
      ST_WAIT_TRIG: begin
        if (trig) state_next = ST_RUN;
      end
      ST_RUN: begin
        if (measure_wrap) begin
          state_next = (batch_end && stop_now) ? ST_IDLE : ST_WAIT_TRIG;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      switch     <= 1'b0;
      stop_latch <= 1'b0;
    end else if (start_go) begin
      switch     <= switch_req;
      stop_latch <= 1'b0;
    end else if (state != ST_IDLE) begin
      if (batch_end) begin
        switch     <= switch_req;
        // Either the stop is being honoured now, or none was pending.
        stop_latch <= 1'b0;
      end else begin
        stop_latch <= stop_now;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      store_strobe <= 1'b0;
    end else begin
      store_strobe <= run && (cnt_measure == STORE_PRE) &&
                      (cnt_point == '0) && !switch;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_save <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start_go) begin
        cnt_save <= '0;
      end else if (store_strobe && (cnt_save < SAVE_FULL)) begin
        cnt_save <= cnt_save + SAVE_W'(1);
        done     <= (cnt_save == SAVE_LAST);
      end
    end
  end

  assign frame_active = (state == ST_RUN);
  assign busy         = (state != ST_IDLE);

endmodule

// File: tb/tb_measure_sequencer.sv
// Self-checking bench for measure_sequencer (POINTS=4, MEASURES=3).
// A frame/batch-level model predicts every output each cycle; a few
// hand-computed literals pin the model at key points.
module tb_measure_sequencer;

  localparam int POINTS     = 4;
  localparam int MEASURES   = 3;
  localparam int FRAME_LEN  = 24;
  localparam int STORE_AT   = 18;
  localparam int SAVE_DEPTH = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        switch_req = 1'b0;
  logic        trig = 1'b0;
  logic [16:0] cnt_measure;
  logic [10:0] cnt_point;
  logic [3:0]  cnt_save;
  logic        switch;
  logic        store_strobe;
  logic        frame_active;
  logic        busy;
  logic        done;

  measure_sequencer #(
    .POINTS    (POINTS),
    .MEASURES  (MEASURES),
    .SAVE_DEPTH(SAVE_DEPTH)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .stop        (stop),
    .switch_req  (switch_req),
    .trig        (trig),
    .cnt_measure (cnt_measure),
    .cnt_point   (cnt_point),
    .cnt_save    (cnt_save),
    .switch      (switch),
    .store_strobe(store_strobe),
    .frame_active(frame_active),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: acquisition on/off, armed vs sweeping, position in
  // frame, frame in batch, stored results, batches completed.
  bit m_busy, m_run, m_sw, m_stop_p, m_done;
  int m_pos, m_frame, m_saved, m_batches;

  function automatic bit m_strobe();
    return m_busy && m_run && m_pos == STORE_AT && m_frame == 0 && !m_sw;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_busy = 0; m_run = 0; m_sw = 0; m_stop_p = 0; m_done = 0;
      m_pos = 0; m_frame = 0; m_saved = 0; m_batches = 0;
    end else begin
      bit st;
      st = m_strobe();
      m_done = 0;
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_run = 0; m_pos = 0; m_frame = 0; m_saved = 0;
          m_sw = switch_req; m_stop_p = 0;
        end
      end else if (!m_run) begin
        m_stop_p = m_stop_p | stop;
        if (trig) m_run = 1;
      end else begin
        m_stop_p = m_stop_p | stop;
        if (st && m_saved < SAVE_DEPTH) begin
          m_saved++;
          if (m_saved == SAVE_DEPTH) m_done = 1;
        end
        if (m_pos == FRAME_LEN - 1) begin
          m_pos = 0;
          m_run = 0;
          if (m_frame == MEASURES - 1) begin
            m_frame = 0;
            m_sw = switch_req;
            m_batches++;
            if (m_stop_p) m_busy = 0;
            m_stop_p = 0;
          end else begin
            m_frame++;
          end
        end else begin
          m_pos++;
        end
      end
    end
  end

  int n_strobe = 0;
  int n_done   = 0;

  always @(negedge clk) begin
    chk("cnt_measure", cnt_measure, m_pos);
    chk("cnt_point", cnt_point, m_frame);
    chk("cnt_save", cnt_save, m_saved);
    chk("switch", switch, m_sw);
    chk("store_strobe", store_strobe, m_strobe());
    chk("frame_active", frame_active, m_busy && m_run);
    chk("busy", busy, m_busy);
    chk("done", done, m_done);
    if (store_strobe === 1'b1) n_strobe++;
    if (done === 1'b1) n_done++;
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(negedge clk);
      #2;
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    chk({tag, "_rst_measure"}, cnt_measure, 0);
    chk({tag, "_rst_point"}, cnt_point, 0);
    chk({tag, "_rst_save"}, cnt_save, 0);
    chk({tag, "_rst_switch"}, switch, 0);
    chk({tag, "_rst_strobe"}, store_strobe, 0);
    chk({tag, "_rst_active"}, frame_active, 0);
    chk({tag, "_rst_busy"}, busy, 0);
    chk({tag, "_rst_done"}, done, 0);
    cyc(2);
    rst = 1'b0;
    cyc(1);
  endtask

  task automatic wait_frame(input int frame, input int pos, input string name);
    int i;
    for (i = 0; i < 400 && !(m_busy && m_run && m_frame == frame && m_pos == pos); i++) cyc(1);
    chk({name, "_reached"}, (m_busy && m_run && m_frame == frame && m_pos == pos), 1);
  endtask

  task automatic wait_batches(input int n, input int budget, input string name);
    int i;
    for (i = 0; i < budget && m_batches < n; i++) cyc(1);
    chk({name, "_reached"}, (m_batches >= n), 1);
  endtask

  task automatic wait_gap(input string name);
    int i;
    for (i = 0; i < 200 && !(m_busy && !m_run); i++) cyc(1);
    chk({name, "_reached"}, (m_busy && !m_run), 1);
  endtask

  task automatic wait_idle(input string name);
    int i;
    for (i = 0; i < 400 && m_busy; i++) cyc(1);
    chk({name, "_reached"}, !m_busy, 1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, d0;

    // 1: basic frame/batch sweep with trig held high
    do_reset("s1");
    trig = 1'b1;
    s0 = n_strobe;
    pulse_start();
    wait_frame(0, STORE_AT, "s1_store");
    chk("s1_strobe_at_store", store_strobe, 1);
    chk("s1_save_before", cnt_save, 0);
    cyc(1);
    chk("s1_save_after", cnt_save, 1);
    wait_batches(1, 200, "s1_batch");
    cyc(3);
    chk("s1_strobes", n_strobe - s0, 1);
    chk("s1_point_wrapped", cnt_point, 0);

    // 2: reset mid-frame, then restart
    wait_frame(0, 10, "s2_mid");
    do_reset("s2");
    trig = 1'b1;
    pulse_start();
    cyc(2);
    chk("s2_measure", cnt_measure, 1);
    chk("s2_save", cnt_save, 0);
    chk("s2_active", frame_active, 1);

    // 3: switch mode suppresses storing until the batch after switch_req drops
    do_reset("s3");
    switch_req = 1'b1;
    trig = 1'b1;
    s0 = n_strobe;
    pulse_start();
    wait_batches(1, 200, "s3_b1");
    wait_frame(1, 5, "s3_mid_b2");
    chk("s3_switch_b2", switch, 1);
    switch_req = 1'b0;
    cyc(1);
    chk("s3_switch_held", switch, 1);
    wait_batches(2, 200, "s3_b2");
    chk("s3_no_strobe", n_strobe - s0, 0);
    chk("s3_save_zero", cnt_save, 0);
    wait_batches(3, 200, "s3_b3");
    chk("s3_strobe_b3", n_strobe - s0, 1);
    chk("s3_save_b3", cnt_save, 1);

    // 4: trig withheld, trig during RUN ignored
    do_reset("s4");
    trig = 1'b0;
    pulse_start();
    cyc(3);
    chk("s4_wait_measure", cnt_measure, 0);
    chk("s4_wait_active", frame_active, 0);
    chk("s4_wait_busy", busy, 1);
    trig = 1'b1; cyc(1); trig = 1'b0;
    cyc(2);
    wait_gap("s4_gap1");
    cyc(5);
    chk("s4_gap_measure", cnt_measure, 0);
    chk("s4_gap_active", frame_active, 0);
    chk("s4_gap_point", cnt_point, 1);
    trig = 1'b1; cyc(1); trig = 1'b0;
    cyc(4);
    trig = 1'b1; cyc(1); trig = 1'b0;
    cyc(2);
    wait_gap("s4_gap2");
    cyc(3);
    chk("s4_ignored_point", cnt_point, 2);
    chk("s4_ignored_active", frame_active, 0);

    // 5: stop mid-batch runs to batch end; stop on batch-end edge
    do_reset("s5");
    trig = 1'b1;
    pulse_start();
    wait_frame(1, 3, "s5_p1");
    stop = 1'b1; cyc(1); stop = 1'b0;
    cyc(5);
    chk("s5_still_busy", busy, 1);
    wait_idle("s5_idle");
    chk("s5_busy", busy, 0);
    chk("s5_point", cnt_point, 0);
    chk("s5_batches", m_batches, 1);
    pulse_start();
    wait_frame(2, FRAME_LEN - 1, "s5_last");
    stop = 1'b1; cyc(1); stop = 1'b0;
    chk("s5_edge_busy", busy, 0);
    chk("s5_edge_active", frame_active, 0);
    cyc(3);
    chk("s5_stays_idle", busy, 0);

    // 6: cnt_save saturation and single done pulse
    do_reset("s6");
    trig = 1'b1;
    switch_req = 1'b0;
    s0 = n_strobe;
    d0 = n_done;
    pulse_start();
    wait_batches(12, 12 * MEASURES * (FRAME_LEN + 2) + 50, "s6_12b");
    cyc(1);
    chk("s6_strobes", n_strobe - s0, 12);
    chk("s6_done_once", n_done - d0, 1);
    chk("s6_save_sat", cnt_save, 10);

    // 7: randomized traffic against the model
    do_reset("s7");
    trig = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      trig       = ($urandom_range(0, 2) == 0);
      start      = ($urandom_range(0, 29) == 0);
      stop       = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 49) == 0) switch_req = ~switch_req;
      rst        = ($urandom_range(0, 999) == 0);
      cyc(1);
    end
    rst = 1'b0; start = 1'b0; stop = 1'b0; trig = 1'b0;
    cyc(2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/measure_sequencer.md
Name: measure_sequencer

Overview:
- Generates the frame-timing counters (cnt_measure, cnt_point, cnt_save) and the switch mode flag that drive the accumulate / divide / store datapath of the Raman acquisition chain.
- Each frame starts on an external trigger, runs a fixed-length cnt_measure sweep, and advances cnt_point.
- One store strobe fires per batch, on frame 0, when not in switch mode; cnt_save counts stored results up to the 10-deep history.
- Start, stop and switch requests are accepted asynchronously and applied only at frame or batch boundaries.

Parameters:
- POINTS, 64, spectral points per frame; FRAME_LEN = 2*POINTS+16, STORE_AT = 2*POINTS+10.
- MEASURES, 100, frames per batch; cnt_point range is 0..MEASURES-1; legal range 1..2048.
- SAVE_DEPTH, 10, saturation value of cnt_save (the history depth).

Ports:
- clk  in  1  system clock; all logic is on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; begins acquisition from IDLE.
- stop  in  1  one-cycle pulse; latched, honoured at the next batch end.
- switch_req  in  1  requested mode; sampled into switch at each batch end and on start.
- trig  in  1  frame trigger (ADC ready); consumed only in WAIT_TRIG.
- cnt_measure  out  17  cycle index within the frame, 0..FRAME_LEN-1.
- cnt_point  out  11  frame index within the batch.
- cnt_save  out  4  number of results stored, saturating at SAVE_DEPTH.
- switch  out  1  mode flag; 1 suppresses storing.
- store_strobe  out  1  one-cycle pulse; the datapath captures a result.
- frame_active  out  1  high while in RUN.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when cnt_save reaches SAVE_DEPTH.

Behaviour:
- Reset (asynchronous, any state): state=IDLE, all outputs 0, stop latch cleared. Reset mid-frame aborts the frame with no strobe.
- States: IDLE, WAIT_TRIG, RUN.
- IDLE:
  - cnt_measure, cnt_point and cnt_save are held at their current values.
  - start → WAIT_TRIG. On that edge: cnt_measure=0, cnt_point=0, cnt_save=0, switch=switch_req, stop latch cleared.
- WAIT_TRIG:
  - Counters hold.
  - trig=1 at edge t → RUN, with cnt_measure=0 visible from t+1.
- RUN:
  - cnt_measure increments by 1 per cycle.
  - At cnt_measure==FRAME_LEN-1:
    - cnt_measure→0.
    - If cnt_point==MEASURES-1 (batch end): cnt_point→0, switch←switch_req; if the stop latch is set → IDLE (stop latch cleared), else → WAIT_TRIG.
    - Otherwise: cnt_point+1, → WAIT_TRIG.
- Every frame requires its own trig. A trig seen in RUN or IDLE is ignored, not queued.
- store_strobe:
  - Registered output, high exactly in the cycle where state==RUN && cnt_measure==STORE_AT && cnt_point==0 && !switch.
  - Exactly one strobe per batch when switch=0; none when switch=1.
- cnt_save:
  - Increments on the edge ending the strobe cycle (the new value is visible one cycle after the strobe).
  - Saturates at SAVE_DEPTH. Further strobes still fire (the history keeps rolling) but do not increment cnt_save.
  - done pulses for one cycle, coincident with the 9→10 update.
- stop:
  - Latched in any non-IDLE state.
  - A stop arriving in the same cycle as the batch-end edge is honoured at that batch end.
- start while busy: ignored.
- start and stop in the same IDLE cycle: start wins, and the stop latch stays clear.
- switch_req changes mid-batch have no effect until the batch end.
- MEASURES=1: every frame is a batch end, so every frame with switch=0 strobes and stop takes effect after one frame.
- frame_active = (state==RUN); busy = (state!=IDLE). Both are decoded from the registered state.
- All counters are unsigned, with width-exact compares against the 17-/11-bit parameter-derived constants.
- Elaboration check: FRAME_LEN ≤ 2^17 and MEASURES ≤ 2048, else $error.

Decomposition:
- Shared package / include measure_seq_pkg:
  - State encoding (IDLE=2'd0, WAIT_TRIG=2'd1, RUN=2'd2).
  - FRAME_PAD=16, STORE_OFFSET=10, SAVE_DEPTH default 10.
  - Width constants 17, 11 and 4, shared with the accumulator, divider and storage blocks.
- One natural sub-module: seq_wrap_counter, a parameterised modulo-N counter with enable, clear and wrap pulse. It is instantiated for cnt_measure and cnt_point.

Test Plan:
All scenarios use POINTS=4, MEASURES=3 (FRAME_LEN=24, STORE_AT=18).
1. Reset, start, trig held high → cnt_measure runs 0..23, cnt_point runs 0,1,2,0. store_strobe fires only while cnt_point=0 && cnt_measure=18; cnt_save=1 one cycle after the strobe.
2. Assert rst while cnt_measure=10 → all outputs 0 immediately, state IDLE. Following start+trig → the sequence restarts at cnt_measure=0 with cnt_save=0.
3. switch_req=1 before start, trig always high, 2 batches → switch=1, no store_strobe, cnt_save=0. Drop switch_req mid-batch 2 → the strobe resumes only in batch 3.
4. trig withheld 5 cycles after frame end → cnt_measure held at 0, frame_active=0, no increment. A trig pulse during RUN is ignored (frame count unchanged).
5. Stop pulse at cnt_point=1 → acquisition continues to the batch end (cnt_point 2→0), then IDLE, busy=0. Stop coincident with the batch-end edge → IDLE at that edge.
6. Run 12 batches with switch=0 → cnt_save reaches 10 at the 10th strobe with a one-cycle done pulse. Strobes 11 and 12 still fire, cnt_save stays 10, and done does not repeat.
